// File: rtl/mips_ctrl_pkg.sv
// State, opcode/funct and control-code definitions shared by the multi-cycle MIPS controller.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_I_EXEC   = 4'd8,
      S_I_WB     = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_JR       = 4'd12,
      S_TRAP     = 4'd13
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] SRCB_RT     = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_RS     = 2'd3;

   function automatic logic [3:0] funct_to_aluop(input logic [5:0] funct);
      logic [3:0] code;
      case (funct)
         FN_SUB:  code = ALU_SUB;
         FN_AND:  code = ALU_AND;
         FN_OR:   code = ALU_OR;
         FN_SLT:  code = ALU_SLT;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

   // Post-DECODE target; any unsupported opcode/funct lands in TRAP.
   function automatic state_e dispatch(input logic [5:0] opcode, input logic [5:0] funct);
      state_e nxt;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: nxt = S_R_EXEC;
               FN_JR:                                 nxt = S_JR;
               default:                               nxt = S_TRAP;
            endcase
         end
         OP_LW, OP_SW:     nxt = S_MEM_ADDR;
         OP_ADDI, OP_ORI:  nxt = S_I_EXEC;
         OP_BEQ, OP_BNE:   nxt = S_BRANCH;
         OP_J:             nxt = S_JUMP;
         default:          nxt = S_TRAP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles and flags the cycle in which the access runs out of time.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mem_req,
   input  logic mem_ready,
   output logic timeout
);

   localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // A ready in the final cycle still completes the access, hence the mem_ready term.
   assign timeout = mem_req && !mem_ready && (count_q == LAST);

   always_comb begin
      count_d = '0;
      if (mem_req && !mem_ready && !timeout) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS sequencer: one control step per clock, memory stalls on MemReady, sticky traps.
module multicycle_ctrl_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] OpCode,
   input  logic [5:0] Funct,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       BranchNeq,
   output logic       IorD,
   output logic       MemRdEn,
   output logic       MemWrEn,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrEn,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ZeroExt,
   output logic [3:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       InvalidInst,
   output logic       BusError
);

   // Memory handshake: a request (MemRdEn/MemWrEn) is held every cycle of the access state;
   // the access completes in the cycle MemReady=1 and MemReady is ignored in all other states.

   state_e     state_q, state_d;
   logic [5:0] op_q, op_d;
   logic [5:0] funct_q, funct_d;
   logic       inv_q, inv_d;
   logic       bus_q, bus_d;
   logic       mem_req;
   logic       mem_timeout;

   assign mem_req = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_req  (mem_req),
      .mem_ready(MemReady),
      .timeout  (mem_timeout)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      funct_d = funct_q;
      inv_d   = inv_q;
      bus_d   = bus_q;
      case (state_q)
         S_FETCH: begin
            if (MemReady) begin
               state_d = S_DECODE;
            end else if (mem_timeout) begin
               state_d = S_TRAP;
               bus_d   = 1'b1;
            end
         end
         S_DECODE: begin
            op_d    = OpCode;
            funct_d = Funct;
            state_d = dispatch(OpCode, Funct);
            if (state_d == S_TRAP) begin
               inv_d = 1'b1;
            end
         end
         S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD, S_MEM_WR: begin
            if (MemReady) begin
               state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
            end else if (mem_timeout) begin
               state_d = S_TRAP;
               bus_d   = 1'b1;
            end
         end
         S_R_EXEC: state_d = S_R_WB;
         S_I_EXEC: state_d = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_TRAP;
      endcase
   end

   // Decoded from state only; the FETCH load strobes additionally qualify on MemReady so IR/PC
   // capture exactly once, at the edge that ends the fetch.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchNeq   = 1'b0;
      IorD        = 1'b0;
      MemRdEn     = 1'b0;
      MemWrEn     = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrEn     = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_RT;
      ZeroExt     = 1'b0;
      ALUOp       = ALU_AND;
      PCSource    = PCSRC_ALU;
      case (state_q)
         S_FETCH: begin
            MemRdEn  = 1'b1;
            ALUSrcB  = SRCB_FOUR;
            ALUOp    = ALU_ADD;
            IRWrite  = MemReady;
            PCWrite  = MemReady;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMM_SH;
            ALUOp   = ALU_ADD;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALU_ADD;
         end
         S_MEM_RD: begin
            IorD    = 1'b1;
            MemRdEn = 1'b1;
         end
         S_MEM_WR: begin
            IorD    = 1'b1;
            MemWrEn = 1'b1;
         end
         S_MEM_WB: begin
            MemtoReg = 1'b1;
            RegWrEn  = 1'b1;
         end
         S_R_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = funct_to_aluop(funct_q);
         end
         S_R_WB: begin
            RegDst  = 1'b1;
            RegWrEn = 1'b1;
         end
         S_I_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            ZeroExt = (op_q == OP_ORI);
            ALUOp   = (op_q == OP_ORI) ? ALU_OR : ALU_ADD;
         end
         S_I_WB: RegWrEn = 1'b1;
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            BranchNeq   = (op_q == OP_BNE);
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
         S_JR: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_RS;
         end
         default: ;
      endcase
   end

   assign InvalidInst = inv_q;
   assign BusError    = bus_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         funct_q <= '0;
         inv_q   <= 1'b0;
         bus_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         funct_q <= funct_d;
         inv_q   <= inv_d;
         bus_q   <= bus_d;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-instruction expected control traces, directed table and random mix.
module tb_multicycle_ctrl_fsm;

   localparam int T = 16;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_neq;
      logic       iord;
      logic       mem_rd;
      logic       mem_wr;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_wr;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       zero_ext;
      logic [3:0] alu_op;
      logic [1:0] pc_source;
      logic       invalid;
      logic       bus_err;
   } ctrl_t;

   typedef struct {
      ctrl_t      exp;
      bit         mem;
      bit         ready;
      bit         dec;
      logic [5:0] op;
      logic [5:0] funct;
   } step_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] funct;
      int         wf;
      int         wm;
      int         lat;
      bit         inv;
      bit         bus;
   } vec_t;

   localparam int K_BAD = 0, K_R = 1, K_JR = 2, K_LW = 3, K_SW = 4, K_I = 5, K_BR = 6, K_J = 7;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] OpCode = '0;
   logic [5:0] Funct = '0;
   logic       MemReady = 1'b0;
   logic       PCWrite, PCWriteCond, BranchNeq, IorD, MemRdEn, MemWrEn, IRWrite;
   logic       MemtoReg, RegDst, RegWrEn, ALUSrcA, ZeroExt, InvalidInst, BusError;
   logic [1:0] ALUSrcB, PCSource;
   logic [3:0] ALUOp;

   ctrl_t act;
   step_t exp_q[$];
   int    total = 0;
   int    bad = 0;

   multicycle_ctrl_fsm #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct(Funct), .MemReady(MemReady),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNeq(BranchNeq), .IorD(IorD),
      .MemRdEn(MemRdEn), .MemWrEn(MemWrEn), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
      .RegDst(RegDst), .RegWrEn(RegWrEn), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ZeroExt(ZeroExt), .ALUOp(ALUOp), .PCSource(PCSource), .InvalidInst(InvalidInst),
      .BusError(BusError)
   );

   always #5 clk = ~clk;

   always_comb act = {PCWrite, PCWriteCond, BranchNeq, IorD, MemRdEn, MemWrEn, IRWrite,
                      MemtoReg, RegDst, RegWrEn, ALUSrcA, ALUSrcB, ZeroExt, ALUOp, PCSource,
                      InvalidInst, BusError};

   // ---------------- reference model ----------------
   function automatic int classify(input logic [5:0] op, input logic [5:0] funct);
      case (op)
         6'h00: begin
            if (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) return K_R;
            if (funct == 6'h08) return K_JR;
            return K_BAD;
         end
         6'h23: return K_LW;
         6'h2B: return K_SW;
         6'h08, 6'h0D: return K_I;
         6'h04, 6'h05: return K_BR;
         6'h02: return K_J;
         default: return K_BAD;
      endcase
   endfunction

   function automatic logic [3:0] r_alu(input logic [5:0] funct);
      case (funct)
         6'h22: return 4'b0110;
         6'h24: return 4'b0000;
         6'h25: return 4'b0001;
         6'h2A: return 4'b0111;
         default: return 4'b0010;
      endcase
   endfunction

   function automatic ctrl_t fetch_vec(input bit rdy);
      ctrl_t c = '0;
      c.mem_rd    = 1'b1;
      c.alu_src_b = 2'd1;
      c.alu_op    = 4'b0010;
      c.ir_write  = rdy;
      c.pc_write  = rdy;
      return c;
   endfunction

   task automatic push(input ctrl_t e, input bit mem, input bit rdy, input bit dec,
                       input logic [5:0] op, input logic [5:0] funct);
      step_t s;
      s.exp = e; s.mem = mem; s.ready = rdy; s.dec = dec; s.op = op; s.funct = funct;
      exp_q.push_back(s);
   endtask

   // An access waiting w cycles: w stalled steps then one ready step, or T stalled steps then trap.
   task automatic push_access(input ctrl_t waiting, input ctrl_t done, input int w, output bit timed_out);
      timed_out = (w >= T);
      for (int k = 0; k < (timed_out ? T : w); k++) push(waiting, 1'b1, 1'b0, 1'b0, 6'h0, 6'h0);
      if (!timed_out) push(done, 1'b1, 1'b1, 1'b0, 6'h0, 6'h0);
   endtask

   task automatic push_trap(input bit inv, input bit bus);
      ctrl_t c = '0;
      c.invalid = inv;
      c.bus_err = bus;
      repeat (2) push(c, 1'b0, 1'b0, 1'b0, 6'h0, 6'h0);
   endtask

   task automatic build_trace(input logic [5:0] op, input logic [5:0] funct, input int wf, input int wm);
      ctrl_t c;
      bit    to;
      int    k;
      exp_q.delete();
      push_access(fetch_vec(1'b0), fetch_vec(1'b1), wf, to);
      if (to) begin
         push_trap(1'b0, 1'b1);
         return;
      end
      c = '0; c.alu_src_b = 2'd3; c.alu_op = 4'b0010;
      push(c, 1'b0, 1'b0, 1'b1, op, funct);
      k = classify(op, funct);
      case (k)
         K_BAD: push_trap(1'b1, 1'b0);
         K_LW, K_SW: begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 4'b0010;
            push(c, 1'b0, 1'b0, 1'b0, 6'h0, 6'h0);
            c = '0; c.iord = 1'b1; c.mem_rd = (k == K_LW); c.mem_wr = (k == K_SW);
            push_access(c, c, wm, to);
            if (to) push_trap(1'b0, 1'b1);
            else if (k == K_LW) begin
               c = '0; c.mem_to_reg = 1'b1; c.reg_wr = 1'b1;
               push(c, 1'b0, 1'b0, 1'b0, 6'h0, 6'h0);
            end
         end
         K_R: begin
            c = '0; c.alu_src_a = 1'b1; c.alu_op = r_alu(funct);
            push(c, 1'b0, 1'b0, 1'b0, 6'h0, 6'h0);
            c = '0; c.reg_dst = 1'b1; c.reg_wr = 1'b1;
            push(c, 1'b0, 1'b0, 1'b0, 6'h0, 6'h0);
         end
         K_I: begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
            c.zero_ext = (op == 6'h0D);
            c.alu_op   = (op == 6'h0D) ? 4'b0001 : 4'b0010;
            push(c, 1'b0, 1'b0, 1'b0, 6'h0, 6'h0);
            c = '0; c.reg_wr = 1'b1;
            push(c, 1'b0, 1'b0, 1'b0, 6'h0, 6'h0);
         end
         K_BR: begin
            c = '0; c.alu_src_a = 1'b1; c.alu_op = 4'b0110; c.pc_write_cond = 1'b1;
            c.pc_source = 2'd1; c.branch_neq = (op == 6'h05);
            push(c, 1'b0, 1'b0, 1'b0, 6'h0, 6'h0);
         end
         K_J, K_JR: begin
            c = '0; c.pc_write = 1'b1; c.pc_source = (k == K_J) ? 2'd2 : 2'd3;
            push(c, 1'b0, 1'b0, 1'b0, 6'h0, 6'h0);
         end
         default: ;
      endcase
   endtask

   // ---------------- checking / driving ----------------
   task automatic check_vec(input string tag, input int idx, input ctrl_t a, input ctrl_t e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s step %0d: got %h want %h", tag, idx, a, e);
      end
   endtask

   task automatic check_int(input string tag, input int a, input int e);
      total++;
      if (a != e) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, a, e);
      end
   endtask

   function automatic bit is_fetch(input ctrl_t a);
      return a.mem_rd && !a.iord && (a.alu_src_b == 2'd1) && !a.invalid && !a.bus_err;
   endfunction

   // Starts just after a negedge; drives one cycle, checks, and returns at the next negedge.
   task automatic drive_step(input step_t s, input string tag, input int idx, output ctrl_t obs);
      OpCode   = s.dec ? s.op : 6'($urandom);
      Funct    = s.dec ? s.funct : 6'($urandom);
      MemReady = s.mem ? s.ready : 1'($urandom);
      #1;
      obs = act;
      check_vec(tag, idx, act, s.exp);
      @(negedge clk);
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input int wf, input int wm,
                            input string tag, output int lat, output logic [1:0] flags);
      ctrl_t obs;
      bit    seen;
      build_trace(op, funct, wf, wm);
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         drive_step(exp_q[i], tag, i, obs);
         if (!is_fetch(obs)) seen = 1'b1;
         else if (seen && lat == 0) lat = i;
      end
      MemReady = 1'b0;
      #1;
      if (seen && lat == 0 && is_fetch(act)) lat = exp_q.size();
      flags = {InvalidInst, BusError};
   endtask

   task automatic do_reset(input string tag);
      rst_n    = 1'b0;
      MemReady = 1'b0;
      #1;
      check_vec(tag, 0, act, fetch_vec(1'b0));
      @(negedge clk);
      #1;
      check_vec(tag, 1, act, fetch_vec(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs[17];
      int         lat;
      logic [1:0] flags;
      ctrl_t      obs;
      logic [5:0] op, fn;
      int         wf, wm;

      vecs[0]  = '{6'h00, 6'h20, 0, 0, 4, 1'b0, 1'b0};   // add
      vecs[1]  = '{6'h00, 6'h22, 1, 0, 5, 1'b0, 1'b0};   // sub, one fetch wait
      vecs[2]  = '{6'h00, 6'h2A, 0, 0, 4, 1'b0, 1'b0};   // slt
      vecs[3]  = '{6'h23, 6'h3F, 0, 3, 8, 1'b0, 1'b0};   // lw, three read waits
      vecs[4]  = '{6'h2B, 6'h00, 0, 0, 4, 1'b0, 1'b0};   // sw
      vecs[5]  = '{6'h05, 6'h11, 0, 0, 3, 1'b0, 1'b0};   // bne
      vecs[6]  = '{6'h04, 6'h00, 2, 0, 5, 1'b0, 1'b0};   // beq, two fetch waits
      vecs[7]  = '{6'h02, 6'h00, 0, 0, 3, 1'b0, 1'b0};   // j
      vecs[8]  = '{6'h00, 6'h08, 0, 0, 3, 1'b0, 1'b0};   // jr
      vecs[9]  = '{6'h0D, 6'h00, 0, 0, 4, 1'b0, 1'b0};   // ori
      vecs[10] = '{6'h08, 6'h00, 0, 0, 4, 1'b0, 1'b0};   // addi
      vecs[11] = '{6'h2B, 6'h00, 0, T - 1, 4 + T - 1, 1'b0, 1'b0}; // ready on last allowed cycle
      vecs[12] = '{6'h2B, 6'h00, 0, T, 0, 1'b0, 1'b1};   // sw stuck
      vecs[13] = '{6'h3F, 6'h00, 0, 0, 0, 1'b1, 1'b0};   // illegal opcode
      vecs[14] = '{6'h00, 6'h3F, 0, 0, 0, 1'b1, 1'b0};   // illegal funct
      vecs[15] = '{6'h23, 6'h00, T, 0, 0, 1'b0, 1'b1};   // fetch timeout
      vecs[16] = '{6'h23, 6'h00, 0, T, 0, 1'b0, 1'b1};   // lw read timeout

      #1;
      check_vec("reset_state", 0, act, fetch_vec(1'b0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 17; v++) begin
         run_instr(vecs[v].op, vecs[v].funct, vecs[v].wf, vecs[v].wm, $sformatf("vec%0d", v), lat, flags);
         check_int($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
         check_int($sformatf("vec%0d_flags", v), int'(flags), int'({vecs[v].inv, vecs[v].bus}));
         if (vecs[v].inv || vecs[v].bus) do_reset($sformatf("vec%0d_reset", v));
      end

      // Reset asserted between clock edges while a store is stalled.
      build_trace(6'h2B, 6'h00, 0, 6);
      for (int i = 0; i < 5; i++) drive_step(exp_q[i], "sw_mid", i, obs);
      MemReady = 1'b0;
      #1;
      check_vec("sw_mid_pre_reset", 5, act, exp_q[5].exp);
      #2;
      rst_n = 1'b0;
      #1;
      check_vec("sw_async_reset", 0, act, fetch_vec(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      run_instr(6'h00, 6'h25, 1, 0, "after_async_reset", lat, flags);
      check_int("after_async_reset_latency", lat, 5);

      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 11))
            0: begin op = 6'h00; fn = 6'h20; end
            1: begin op = 6'h00; fn = 6'h22; end
            2: begin op = 6'h00; fn = 6'h24; end
            3: begin op = 6'h00; fn = 6'h25; end
            4: begin op = 6'h00; fn = 6'h2A; end
            5: begin op = 6'h00; fn = 6'h08; end
            6: begin op = 6'h23; fn = 6'($urandom); end
            7: begin op = 6'h2B; fn = 6'($urandom); end
            8: begin op = ($urandom_range(0, 1) == 0) ? 6'h08 : 6'h0D; fn = 6'($urandom); end
            9: begin op = ($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05; fn = 6'($urandom); end
            10: begin op = 6'h02; fn = 6'($urandom); end
            default: begin op = 6'h3F; fn = 6'($urandom); end
         endcase
         wf = ($urandom_range(0, 15) == 0) ? $urandom_range(T - 1, T + 1) : $urandom_range(0, 2);
         wm = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 1, T + 1) : $urandom_range(0, 3);
         run_instr(op, fn, wf, wm, $sformatf("rand%0d", n), lat, flags);
         if (flags != 2'b00) do_reset($sformatf("rand%0d_reset", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
